// File: rtl/wb_crc32_master.sv
// rtl/wb_crc32_master.sv - Wishbone B4 pipelined read initiator computing IEEE 802.3 CRC-32 over a word block
// Optional ack/stall watchdog enabled by defining WB_CRC_TIMEOUT_EN.
module wb_crc32_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           crc,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_stall_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] remaining;
  logic [31:0]          run_crc;
  logic                 wd_expired;

  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hF;
  assign wb_dat_o = 32'h0;

  // Bit-serial reflected CRC over the whole word: LSB of byte0 first, which is zlib byte order.
  function automatic logic [31:0] crc_fold(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 32; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

`ifdef WB_CRC_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;

  assign wd_expired = (wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd <= '0;
    end else if (state == IDLE || (state == REQ && !wb_stall_i) || (state == WAIT && wb_ack_i)) begin
      wd <= '0;
    end else if (state == REQ || state == WAIT) begin
      wd <= wd + WD_W'(1);
    end
  end
`else
  // No watchdog: never expires, so the block waits indefinitely on stall or ack.
  assign wd_expired = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      crc       <= 32'h0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_adr_o  <= '0;
      remaining <= '0;
      run_crc   <= 32'hFFFFFFFF;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wb_adr_o  <= base_addr & ~ADDR_WIDTH'(3);
            remaining <= num_words;
            run_crc   <= 32'hFFFFFFFF;
            err       <= 1'b0;
            busy      <= 1'b1;
            if (num_words == '0) begin
              state <= FIN;
            end else begin
              state    <= REQ;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
            end
          end
        end
        REQ: begin
          if (!wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= WAIT;
          end else if (wd_expired) begin
            err      <= 1'b1;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state    <= FIN;
          end
        end
        WAIT: begin
          // A bus error beats a simultaneous ack; the data of that beat is dropped.
          if (wb_err_i) begin
            err      <= 1'b1;
            wb_cyc_o <= 1'b0;
            state    <= FIN;
          end else if (wb_ack_i) begin
            run_crc   <= crc_fold(run_crc, wb_dat_i);
            wb_adr_o  <= wb_adr_o + ADDR_WIDTH'(4);
            remaining <= remaining - CNT_WIDTH'(1);
            if (remaining == CNT_WIDTH'(1)) begin
              wb_cyc_o <= 1'b0;
              state    <= FIN;
            end else begin
              wb_stb_o <= 1'b1;
              state    <= REQ;
            end
          end else if (wd_expired) begin
            err      <= 1'b1;
            wb_cyc_o <= 1'b0;
            state    <= FIN;
          end
        end
        FIN: begin
          crc   <= run_crc ^ 32'hFFFFFFFF;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
